// File: rtl/writeback_queue.sv
// writeback_queue: small circular FIFO of pending register-file writebacks.
// Entries {rd, data} drain one per cycle into a registered write port
// (wb_en/wb_rd/wb_data). Requests with rd==0 complete the handshake but are
// not stored, since x0 is never written.
// Optional operand forwarding is compiled in when the macro WBQ_FWD_EN is
// defined; otherwise the fwd_* outputs are tied to zero.
module writeback_queue #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [4:0]              in_rd,
  input  logic [XLEN-1:0]         in_data,
  output logic                    wb_en,
  output logic [4:0]              wb_rd,
  output logic [XLEN-1:0]         wb_data,
  input  logic [4:0]              fwd_rs1,
  input  logic [4:0]              fwd_rs2,
  output logic                    fwd_rs1_hit,
  output logic                    fwd_rs2_hit,
  output logic [XLEN-1:0]         fwd_rs1_data,
  output logic [XLEN-1:0]         fwd_rs2_data,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    empty,
  output logic                    full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // Entry storage is a plain register array: forwarding needs to look at
  // every slot combinationally, so a synchronous-read RAM would not work.
  logic [4:0]      mem_rd_q   [DEPTH];
  logic [XLEN-1:0] mem_data_q [DEPTH];

  logic [PW-1:0]   head_q, head_d;
  logic [PW-1:0]   tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;
  logic            wb_en_q, wb_en_d;
  logic [4:0]      wb_rd_q, wb_rd_d;
  logic [XLEN-1:0] wb_data_q, wb_data_d;

  logic push;
  logic pop;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(DEPTH));
  assign in_ready = !full;
  assign count    = count_q;

  // Writes to x0 are swallowed: handshake completes, nothing is stored.
  assign push = in_valid && in_ready && (in_rd != 5'd0);
  // Pop decision uses pre-edge occupancy, so a same-edge push is never popped.
  assign pop  = !empty;

  assign wb_en   = wb_en_q;
  assign wb_rd   = wb_rd_q;
  assign wb_data = wb_data_q;

  // Pointer and occupancy next-state.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push) tail_d = tail_q + PW'(1);
    if (pop)  head_d = head_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Writeback register next-state: head entry when non-empty, else idle
  // with index/data held.
  always_comb begin
    wb_en_d   = 1'b0;
    wb_rd_d   = wb_rd_q;
    wb_data_d = wb_data_q;
    if (pop) begin
      wb_en_d   = 1'b1;
      wb_rd_d   = mem_rd_q[head_q];
      wb_data_d = mem_data_q[head_q];
    end
  end

  // Control state and writeback register, cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      wb_en_q   <= 1'b0;
      wb_rd_q   <= '0;
      wb_data_q <= '0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      wb_en_q   <= wb_en_d;
      wb_rd_q   <= wb_rd_d;
      wb_data_q <= wb_data_d;
    end
  end

  // Entry storage write; contents need no reset because occupancy gates them.
  always_ff @(posedge clk) begin
    if (resetn && push) begin
      mem_rd_q[tail_q]   <= in_rd;
      mem_data_q[tail_q] <= in_data;
    end
  end

`ifdef WBQ_FWD_EN
  // Returns {hit, data}. The wb register is the oldest candidate, then the
  // queued entries from head (oldest) to tail (youngest); later matches
  // overwrite earlier ones, so the youngest pending value wins.
  function automatic logic [XLEN:0] fwd_lookup(input logic [4:0] rs);
    logic            hit;
    logic [XLEN-1:0] data;
    logic [PW-1:0]   idx;
    hit  = 1'b0;
    data = '0;
    if (rs != 5'd0) begin
      if (wb_en_q && (wb_rd_q == rs)) begin
        hit  = 1'b1;
        data = wb_data_q;
      end
      for (int i = 0; i < DEPTH; i++) begin
        idx = head_q + PW'(i);
        if ((CW'(i) < count_q) && (mem_rd_q[idx] == rs)) begin
          hit  = 1'b1;
          data = mem_data_q[idx];
        end
      end
    end
    return {hit, data};
  endfunction

  logic [XLEN:0] fwd1_res;
  logic [XLEN:0] fwd2_res;

  // Combinational forwarding for both source operands.
  always_comb begin
    fwd1_res = fwd_lookup(fwd_rs1);
    fwd2_res = fwd_lookup(fwd_rs2);
  end

  assign fwd_rs1_hit  = fwd1_res[XLEN];
  assign fwd_rs1_data = fwd1_res[XLEN-1:0];
  assign fwd_rs2_hit  = fwd2_res[XLEN];
  assign fwd_rs2_data = fwd2_res[XLEN-1:0];
`else
  // Forwarding compiled out: source indices are intentionally ignored.
  logic unused_fwd;
  assign unused_fwd = ^{fwd_rs1, fwd_rs2};

  assign fwd_rs1_hit  = 1'b0;
  assign fwd_rs2_hit  = 1'b0;
  assign fwd_rs1_data = '0;
  assign fwd_rs2_data = '0;
`endif

endmodule

// File: doc/writeback_queue.md
WRITEBACK_QUEUE -- requirements
Module: writeback_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of pending writeback entries (power of two, 2..16).
REQ-002 Parameter XLEN, default 32, data width.
REQ-003 clk  input  1  clock; all state updates on posedge clk.
REQ-004 resetn  input  1  reset; synchronous, active-low.
REQ-005 in_valid  input  1  writeback request present.
REQ-006 in_ready  output  1  queue can accept a request this cycle.
REQ-007 in_rd  input  5  destination register index.
REQ-008 in_data  input  XLEN  destination value.
REQ-009 wb_en  output  1  register-file write enable, registered.
REQ-010 wb_rd  output  5  register-file write index, registered.
REQ-011 wb_data  output  XLEN  register-file write data, registered.
REQ-012 fwd_rs1, fwd_rs2  input  5 each  source indices being read from the register file.
REQ-013 fwd_rs1_hit, fwd_rs2_hit  output  1 each  pending newer value exists, combinational.
REQ-014 fwd_rs1_data, fwd_rs2_data  output  XLEN each  forwarded value, combinational.
REQ-015 count  output  $clog2(DEPTH)+1  entries held; empty, full  output  1 each  count==0, count==DEPTH.

Function
REQ-016 Circular FIFO, head/tail pointers wrap modulo DEPTH; entries are {rd, data}.
REQ-017 in_ready SHALL equal !full; no same-cycle push-through when full.
REQ-018 Push occurs on an edge where in_valid && in_ready && in_rd!=0; requests with in_rd==0 SHALL be accepted (handshake completes) but not enqueued.
REQ-019 Each edge with !empty SHALL pop the head into wb_rd/wb_data with wb_en=1; each edge with empty SHALL set wb_en=0 (wb_rd/wb_data hold).
REQ-020 Latency: request accepted at edge N into an empty queue appears with wb_en=1 after edge N+1; drain rate one entry per cycle.
REQ-021 Simultaneous push and pop in one edge SHALL leave count unchanged; pushed entry SHALL never be popped on the edge it is pushed.
REQ-022 Writes are retired strictly in acceptance order; multiple entries to the same rd are all retired.
REQ-023 Forwarding lookup for rsX (rsX!=0) SHALL search queued entries youngest-first, then the wb output register when wb_en=1; first match drives hit=1 and its data.
REQ-024 rsX==0 or no match SHALL give hit=0, data=0.
REQ-025 Forwarding covers wb register because the register file commits at the same edge its registered read samples the old value.

Reset
REQ-026 While resetn=0 at an edge: count=0, pointers=0, wb_en=0, wb_rd=0, wb_data=0; pending entries discarded; no push or pop that edge.
REQ-027 Reset mid-drain SHALL drop all remaining entries; no wb_en pulse after reset edge until a new push.
REQ-028 Output values after reset: in_ready=1, empty=1, full=0, both hits=0.

Configuration
REQ-029 Macro WBQ_FWD_EN: when defined, forwarding per REQ-023..025 is compiled in.
REQ-030 When WBQ_FWD_EN is undefined, fwd_* inputs are ignored and fwd_rs1_hit, fwd_rs2_hit, fwd_rs1_data, fwd_rs2_data are constant 0; queue behaviour otherwise identical.

Verification
REQ-031 Single push rd=5 data=0xDEADBEEF into empty queue -> wb_en=1, wb_rd=5, wb_data=0xDEADBEEF exactly one cycle after acceptance, wb_en=0 next cycle.
REQ-032 Hold wb drain impossible by pushing 5 back-to-back with DEPTH=4 at one push/cycle -> count never exceeds 4, all 5 retire in order, in_ready=0 only on cycles where full=1.
REQ-033 Push rd=0 data=0x1234 -> in handshake completes, count stays 0, no wb_en pulse.
REQ-034 Push rd=7 data=1 then rd=7 data=2 back-to-back, fwd_rs1=7 -> hit=1 with data=2 while both pending, data=2 while in wb register, hit=0 afterwards.
REQ-035 Fill with 3 entries, assert resetn=0 for one edge -> count=0, wb_en=0, no further writes emitted.
REQ-036 Rebuild without WBQ_FWD_EN, repeat REQ-034 stimulus -> hits and data stay 0, wb sequence unchanged.
